// File: rtl/cnn_frame_sequencer.sv
// Frame-level controller for the conv -> relu -> pool datapath: feeds pixels, drains the
// pipeline with zero beats, and buffers pooled results in a small first-word-fall-through FIFO.
module cnn_frame_sequencer #(
    parameter int unsigned IN_WIDTH   = 49,
    parameter int unsigned OUT_WIDTH  = 81,
    parameter int unsigned IMAGE_SIZE = 256,
    parameter int unsigned OUT_COUNT  = 16129,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SKID       = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overflow,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 dp_clk_en,
    output logic [IN_WIDTH-1:0]  dp_in_data,
    input  logic                 dp_valid,
    input  logic [OUT_WIDTH-1:0] dp_out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data
);

    localparam int unsigned PIX_TOTAL = IMAGE_SIZE * IMAGE_SIZE;
    localparam int unsigned PIX_W     = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1;
    localparam int unsigned RES_W     = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [PIX_W-1:0]       r_pix_cnt;
    logic [RES_W-1:0]       r_res_cnt;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_fifo_cnt;
    logic [OUT_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic                   r_overflow;

    logic w_can_go;
    logic w_active;
    logic w_accept;
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_drop;
    logic w_last_pix;
    logic w_last_res;
    logic w_frame_start;

    // Keep SKID entries free so results already in flight always have a slot.
    assign w_can_go      = (CNT_W'(FIFO_DEPTH) - r_fifo_cnt) >= CNT_W'(SKID);
    assign w_active      = (r_state == StRun) || (r_state == StDrain);
    assign w_accept      = (r_state == StRun) && in_valid && w_can_go;
    assign w_pop         = (r_fifo_cnt != '0) && out_ready;
    assign w_full        = (r_fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign w_push        = dp_valid && w_active && (!w_full || w_pop);
    assign w_drop        = dp_valid && !w_push;
    assign w_last_pix    = w_accept && (r_pix_cnt == PIX_W'(PIX_TOTAL - 1));
    assign w_last_res    = w_push && (r_res_cnt == RES_W'(OUT_COUNT - 1));
    assign w_frame_start = (r_state == StIdle) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        frame_done   = 1'b0;
        in_ready     = 1'b0;
        dp_clk_en    = 1'b0;
        dp_in_data   = '0;
        unique case (r_state)
            StIdle: begin
                if (start) w_state_next = StRun;
            end
            StRun: begin
                busy       = 1'b1;
                in_ready   = w_can_go;
                dp_clk_en  = w_accept;
                dp_in_data = in_data;
                if (w_last_res) begin
                    w_state_next = StDone;
                end else if (w_last_pix) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                busy      = 1'b1;
                dp_clk_en = w_can_go;
                if (w_last_res) w_state_next = StDone;
            end
            StDone: begin
                frame_done   = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt  <= '0;
            r_res_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_frame_start) begin
                r_pix_cnt <= '0;
                r_res_cnt <= '0;
            end else begin
                if (w_accept) r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                if (w_push)   r_res_cnt <= r_res_cnt + RES_W'(1);
            end
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // Not flushed between frames: a previous frame's results may still be draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= dp_out_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
            end
        end
    end

    assign out_valid = (r_fifo_cnt != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Bench for cnn_frame_sequencer: directed frames with a 4-in/1-out datapath model feeding a
// result scoreboard; a negedge monitor checks pixels, drain beats and popped results.
module tb_cnn_frame_sequencer;

    localparam int unsigned IW   = 49;
    localparam int unsigned OW   = 81;
    localparam int unsigned IMG  = 4;
    localparam int unsigned NPIX = IMG * IMG;
    localparam int unsigned OC   = 4;
    localparam int unsigned FD   = 4;
    localparam int unsigned SK   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          force_valid = 1'b0;
    logic          abort = 1'b0;
    logic          busy, frame_done, overflow, in_ready, dp_clk_en, out_valid;
    logic [IW-1:0] dp_in_data;
    logic [OW-1:0] out_data;
    logic          dp_valid;
    logic [OW-1:0] dp_out_data;
    logic          m_valid = 1'b0;
    logic [OW-1:0] m_data = '0;

    assign dp_valid    = m_valid | force_valid;
    assign dp_out_data = m_data;

    cnn_frame_sequencer #(
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .IMAGE_SIZE(IMG),
        .OUT_COUNT (OC),
        .FIFO_DEPTH(FD),
        .SKID      (SK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .dp_clk_en  (dp_clk_en),
        .dp_in_data (dp_in_data),
        .dp_valid   (dp_valid),
        .dp_out_data(dp_out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [OW-1:0] exp_q[$];
    logic [IW-1:0] pix_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Datapath model: one pooled result, one cycle after every 4th enable.
    int en_cnt = 0;
    int res_idx = 0;
    int frame_tag = 0;
    bit pend = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            pend    = 1'b0;
            en_cnt  = 0;
            res_idx = 0;
            exp_q.delete();
        end else begin
            m_valid = pend;
            if (pend) begin
                m_data = OW'(frame_tag * 256 + res_idx);
                exp_q.push_back(m_data);
                res_idx++;
            end
            pend = 1'b0;
            if (dp_clk_en) begin
                en_cnt++;
                if (en_cnt % 4 == 0) pend = 1'b1;
            end
            if (frame_done) begin
                en_cnt  = 0;
                res_idx = 0;
                frame_tag++;
            end
        end
    end

    // Monitor: per-frame statistics, latched into s_* on frame_done.
    int cyc = 0;
    int done_cnt = 0;
    int f_acc = 0, f_drain = 0, f_drain_bad = 0, f_viol = 0, f_first = -1, f_last = -1;
    int s_acc = 0, s_drain = 0, s_drain_bad = 0, s_viol = 0, s_span = 0;
    bit prev_busy = 1'b0;
    always @(negedge clk) begin
        logic [OW-1:0] e;
        logic [IW-1:0] p;
        cyc++;
        if (!rst_n) begin
            pix_q.delete();
            f_acc = 0; f_drain = 0; f_drain_bad = 0; f_viol = 0; f_first = -1; f_last = -1;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) e = exp_q.pop_front();
                else e = '1;
                check("out_data", out_data, e);
            end
            if (busy && in_ready) begin
                if (dp_clk_en !== in_valid) f_viol++;
                if (dp_clk_en) begin
                    f_acc++;
                    if (f_first < 0) f_first = cyc;
                    f_last = cyc;
                    if (pix_q.size() != 0) p = pix_q.pop_front();
                    else p = '1;
                    check("dp_in_data", dp_in_data, p);
                end
            end else if (busy && dp_clk_en) begin
                f_drain++;
                if (dp_in_data != '0) f_drain_bad++;
            end
            if (frame_done) begin
                done_cnt++;
                check("busy_fall", {busy, prev_busy}, 2'b01);
                s_acc = f_acc; s_drain = f_drain; s_drain_bad = f_drain_bad; s_viol = f_viol;
                s_span = f_last - f_first + 1;
                f_acc = 0; f_drain = 0; f_drain_bad = 0; f_viol = 0; f_first = -1; f_last = -1;
            end
        end
        prev_busy = busy;
    end

    int px_base = 0;
    int done_base = 0;

    task automatic start_frame();
        done_base = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_pixels(input bit toggle);
        int i = 0;
        int guard = 0;
        bit phase = 1'b1;
        bit pushed = 1'b0;
        bit acc;
        logic [IW-1:0] v;
        while (i < int'(NPIX) && !abort && guard < 400) begin
            v = IW'(px_base + i + 1);
            if (!pushed) begin
                pix_q.push_back(v);
                pushed = 1'b1;
            end
            in_valid = toggle ? phase : 1'b1;
            in_data  = v;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                i++;
                pushed = 1'b0;
            end
            phase = ~phase;
            guard++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        px_base += 64;
        if (!abort) check("pix_sent", i, NPIX);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == done_base && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, done_cnt - done_base, 1);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_pix_left"}, pix_q.size(), 0);
    endtask

    task automatic frame_stats(input string name, input int drains);
        check({name, "_acc"}, s_acc, NPIX);
        check({name, "_drain"}, s_drain, drains);
        check({name, "_drain_zero"}, s_drain_bad, 0);
        check({name, "_en_viol"}, s_viol, 0);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_clk_en", dp_clk_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_dp_in", dp_in_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: streaming frame, no backpressure
        out_ready = 1'b1;
        start_frame();
        drive_pixels(1'b0);
        wait_done("t1");
        frame_stats("t1", 1);
        check("t1_span", s_span, NPIX);
        check("t1_ovf", overflow, 0);

        // 2: downstream stalled; throttle after 13 pixels (FIFO at 3)
        out_ready = 1'b0;
        start_frame();
        fork
            drive_pixels(1'b0);
            begin
                repeat (30) @(negedge clk);
                check("t2_stall_acc", f_acc, 13);
                check("t2_stall_ready", in_ready, 0);
                check("t2_stall_en", dp_clk_en, 0);
                check("t2_stall_busy", busy, 1);
                check("t2_stall_ovalid", out_valid, 1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_done("t2");
        frame_stats("t2", 1);
        check("t2_ovf", overflow, 0);

        // 3: in_valid toggling
        start_frame();
        drive_pixels(1'b1);
        wait_done("t3");
        frame_stats("t3", 1);

        // 4: start pulses during RUN and DRAIN are ignored
        start_frame();
        fork
            drive_pixels(1'b0);
            begin
                n = 0;
                while (f_acc < 5 && n < 100) begin @(negedge clk); n++; end
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                n = 0;
                while (!(busy && !in_ready) && n < 100) begin @(negedge clk); n++; end
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        wait_done("t4");
        frame_stats("t4", 1);
        repeat (6) @(negedge clk);
        check("t4_no_restart", busy, 0);
        check("t4_one_done", done_cnt - done_base, 1);
        @(posedge clk); #1;
        start_frame();
        drive_pixels(1'b0);
        wait_done("t4b");
        frame_stats("t4b", 1);
        check("t4b_span", s_span, NPIX);

        // 5: stray dp_valid in IDLE
        repeat (3) @(posedge clk);
        #1;
        check("t5_ovf_before", overflow, 0);
        force_valid = 1'b1;
        @(posedge clk); #1;
        force_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5_fifo_empty", out_valid, 0);
        check("t5_ovf", overflow, 1);

        // 6: reset mid-RUN with two results buffered
        out_ready = 1'b0;
        start_frame();
        fork
            drive_pixels(1'b0);
            begin
                n = 0;
                while (!(res_idx == 2 && !m_valid && out_valid) && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("t6_ovf_held", overflow, 1);
                check("t6_buffered", out_valid, 1);
                @(posedge clk); #3;
                rst_n = 1'b0;
                #1;
                check("t6_busy", busy, 0);
                check("t6_in_ready", in_ready, 0);
                check("t6_clk_en", dp_clk_en, 0);
                check("t6_out_valid", out_valid, 0);
                check("t6_ovf", overflow, 0);
                check("t6_done", frame_done, 0);
                check("t6_dp_in", dp_in_data, 0);
                abort = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        start_frame();
        drive_pixels(1'b0);
        wait_done("t6");
        frame_stats("t6", 1);
        check("t6_ovf_after", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
